// File: rtl/kgp_isa_pkg.sv
// Shared ISA definitions for the decode stage: opClass codes, instruction field
// positions and per-class register usage helpers.
package kgp_isa_pkg;

    localparam logic [2:0] OC_ALU_R  = 3'd0;
    localparam logic [2:0] OC_ALU_I  = 3'd1;
    localparam logic [2:0] OC_LOAD   = 3'd2;
    localparam logic [2:0] OC_STORE  = 3'd3;
    localparam logic [2:0] OC_BRANCH = 3'd4;
    localparam logic [2:0] OC_JAL    = 3'd5;

    localparam int OC_HI   = 31;
    localparam int OC_LO   = 29;
    localparam int SUB_HI  = 28;
    localparam int SUB_LO  = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;
    localparam int FUNC_HI = 4;
    localparam int FUNC_LO = 0;

    typedef struct packed {
        logic [2:0] op_class;
        logic [2:0] sub_op;
        logic [4:0] func;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       reg_write;
        logic       illegal;
    } id_ctrl_t;

    // NOTE: every case carries a default so the combinational result is always driven (no latch).
    function automatic logic reads_rs(input logic [2:0] oc);
        case (oc)
            OC_ALU_R, OC_ALU_I, OC_LOAD, OC_STORE, OC_BRANCH: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rt(input logic [2:0] oc);
        case (oc)
            OC_ALU_R, OC_STORE: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic logic writes_reg(input logic [2:0] oc);
        case (oc)
            OC_ALU_R, OC_ALU_I, OC_LOAD, OC_JAL: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_field_decoder.sv
// Purely combinational field extraction for one instruction word, including
// immediate extension and the register-usage flags used by hazard detection.
module instr_field_decoder
    import kgp_isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [2:0]      o_op_class,
    output logic [2:0]      o_sub_op,
    output logic [4:0]      o_func,
    output logic [4:0]      o_rs,
    output logic [4:0]      o_rt,
    output logic [XLEN-1:0] o_imm,
    output logic            o_reg_write,
    output logic            o_illegal,
    output logic            o_rd_rs,
    output logic            o_rd_rt
);

    logic [15:0] w_imm16;
    logic        w_zext;

    assign o_op_class = i_instr[OC_HI:OC_LO];
    assign o_sub_op   = i_instr[SUB_HI:SUB_LO];
    assign o_func     = i_instr[FUNC_HI:FUNC_LO];
    assign o_rs       = i_instr[RS_HI:RS_LO];
    assign o_rt       = i_instr[RT_HI:RT_LO];
    assign w_imm16    = i_instr[IMM_HI:IMM_LO];

    // Only ALU_I with subOp[0] set treats its immediate as unsigned.
    assign w_zext = (o_op_class == OC_ALU_I) & o_sub_op[0];
    assign o_imm  = w_zext ? {{(XLEN-16){1'b0}}, w_imm16}
                           : {{(XLEN-16){w_imm16[15]}}, w_imm16};

    assign o_illegal   = (o_op_class > OC_JAL);
    assign o_reg_write = writes_reg(o_op_class);
    assign o_rd_rs     = reads_rs(o_op_class);
    assign o_rd_rt     = reads_rt(o_op_class);

endmodule

// File: rtl/instr_decode_stage.sv
// Fetch-to-register-file decode stage: one output register behind a valid/ready
// handshake, load-use bubble insertion, flush, and a saturating stall counter.
module instr_decode_stage
    import kgp_isa_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [2:0]       id_opClass,
    output logic [2:0]       id_subOp,
    output logic [4:0]       id_func,
    output logic [4:0]       id_reg_1,
    output logic [4:0]       id_reg_2,
    output logic [XLEN-1:0]  id_imm,
    output logic             id_regWrite,
    output logic             id_illegal,
    output logic [CNT_W-1:0] hazard_cnt
);

    logic [2:0]      w_op_class;
    logic [2:0]      w_sub_op;
    logic [4:0]      w_func;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [XLEN-1:0] w_imm;
    logic            w_reg_write;
    logic            w_illegal;
    logic            w_rd_rs;
    logic            w_rd_rt;
    logic            w_haz;
    logic            w_accept;
    logic            w_cnt_inc;

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_imm;
    id_ctrl_t         r_ctrl;
    logic [CNT_W-1:0] r_cnt;

    instr_field_decoder #(.XLEN(XLEN)) u_dec (
        .i_instr     (if_instr),
        .o_op_class  (w_op_class),
        .o_sub_op    (w_sub_op),
        .o_func      (w_func),
        .o_rs        (w_rs),
        .o_rt        (w_rt),
        .o_imm       (w_imm),
        .o_reg_write (w_reg_write),
        .o_illegal   (w_illegal),
        .o_rd_rs     (w_rd_rs),
        .o_rd_rt     (w_rd_rt)
    );

    // A held LOAD blocks any incoming instruction that actually reads its rt,
    // including in the cycle the LOAD itself leaves.
    assign w_haz = r_valid & (r_ctrl.op_class == OC_LOAD)
                 & ((w_rd_rs & (w_rs == r_ctrl.rt)) | (w_rd_rt & (w_rt == r_ctrl.rt)));

    assign if_ready  = (~r_valid | id_ready) & ~w_haz & ~flush;
    assign w_accept  = if_valid & if_ready;
    assign w_cnt_inc = if_valid & w_haz & ~flush & ~(&r_cnt);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload is reset too, because every output must read zero out of reset.
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_imm   <= '0;
            r_ctrl  <= '0;
            r_cnt   <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid          <= 1'b1;
                r_pc             <= if_pc;
                r_imm            <= w_imm;
                r_ctrl.op_class  <= w_op_class;
                r_ctrl.sub_op    <= w_sub_op;
                r_ctrl.func      <= w_func;
                r_ctrl.rs        <= w_rs;
                r_ctrl.rt        <= w_rt;
                r_ctrl.reg_write <= w_reg_write;
                r_ctrl.illegal   <= w_illegal;
            end else if (r_valid & id_ready) begin
                r_valid <= 1'b0;
            end

            if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign id_valid    = r_valid;
    assign id_pc       = r_pc;
    assign id_imm      = r_imm;
    assign id_opClass  = r_ctrl.op_class;
    assign id_subOp    = r_ctrl.sub_op;
    assign id_func     = r_ctrl.func;
    assign id_reg_1    = r_ctrl.rs;
    assign id_reg_2    = r_ctrl.rt;
    assign id_regWrite = r_ctrl.reg_write;
    assign id_illegal  = r_ctrl.illegal;
    assign hazard_cnt  = r_cnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomised and directed bench for instr_decode_stage against a table-driven
// reference model of the held instruction and stall counter.
module tb_instr_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             if_valid;
    logic             if_ready;
    logic [31:0]      if_instr;
    logic [XLEN-1:0]  if_pc;
    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_pc;
    logic [2:0]       id_opClass;
    logic [2:0]       id_subOp;
    logic [4:0]       id_func;
    logic [4:0]       id_reg_1;
    logic [4:0]       id_reg_2;
    logic [XLEN-1:0]  id_imm;
    logic             id_regWrite;
    logic             id_illegal;
    logic [CNT_W-1:0] hazard_cnt;

    instr_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_opClass  (id_opClass),
        .id_subOp    (id_subOp),
        .id_func     (id_func),
        .id_reg_1    (id_reg_1),
        .id_reg_2    (id_reg_2),
        .id_imm      (id_imm),
        .id_regWrite (id_regWrite),
        .id_illegal  (id_illegal),
        .hazard_cnt  (hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register usage per opClass 0..7, straight from the ISA table.
    bit READS_RS [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    bit READS_RT [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
    bit WRITES   [8] = '{1, 1, 1, 0, 0, 1, 0, 0};

    typedef struct {
        int unsigned op;
        int unsigned sub;
        int unsigned func;
        int unsigned rs;
        int unsigned rt;
        int unsigned imm;
        int unsigned pc;
        bit          rw;
        bit          ill;
    } rec_t;

    int   n_tests;
    int   n_fail;
    bit   m_valid;
    rec_t m_rec;
    int   m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t ref_decode(input int unsigned w, input int unsigned pc);
        rec_t r;
        int unsigned imm16;
        r.op   = (w >> 29) & 7;
        r.sub  = (w >> 26) & 7;
        r.rs   = (w >> 21) & 31;
        r.rt   = (w >> 16) & 31;
        r.func = w & 31;
        imm16  = w & 32'hFFFF;
        if (r.op == 1 && (r.sub % 2) == 1)
            r.imm = imm16;
        else
            r.imm = (imm16 >= 32768) ? imm16 + 32'hFFFF_0000 : imm16;
        r.rw  = WRITES[r.op];
        r.ill = (r.op >= 6);
        r.pc  = pc;
        return r;
    endfunction

    // One clock cycle: drive at negedge, check against the model, advance the model,
    // return just after the posedge so callers can inspect the new registered state.
    task automatic step(input bit t_rst, input bit t_flush, input bit t_valid,
                        input logic [31:0] t_instr, input logic [31:0] t_pc, input bit t_ready);
        rec_t in_rec;
        bit   haz;
        bit   exp_rdy;
        @(negedge clk);
        rst      = t_rst;
        flush    = t_flush;
        if_valid = t_valid;
        if_instr = t_instr;
        if_pc    = t_pc;
        id_ready = t_ready;
        #1;
        in_rec  = ref_decode(t_instr, t_pc);
        haz     = m_valid && m_rec.op == 2 &&
                  ((READS_RS[in_rec.op] && in_rec.rs == m_rec.rt) ||
                   (READS_RT[in_rec.op] && in_rec.rt == m_rec.rt));
        exp_rdy = (!m_valid || t_ready) && !haz && !t_flush;

        check("if_ready",   32'(if_ready),   32'(exp_rdy));
        check("id_valid",   32'(id_valid),   32'(m_valid));
        check("hazard_cnt", 32'(hazard_cnt), 32'(m_cnt));
        if (m_valid) begin
            check("id_pc",       id_pc,             m_rec.pc);
            check("id_opClass",  32'(id_opClass),   m_rec.op);
            check("id_subOp",    32'(id_subOp),     m_rec.sub);
            check("id_func",     32'(id_func),      m_rec.func);
            check("id_reg_1",    32'(id_reg_1),     m_rec.rs);
            check("id_reg_2",    32'(id_reg_2),     m_rec.rt);
            check("id_imm",      id_imm,            m_rec.imm);
            check("id_regWrite", 32'(id_regWrite),  32'(m_rec.rw));
            check("id_illegal",  32'(id_illegal),   32'(m_rec.ill));
        end

        if (t_rst) begin
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            if (!t_flush && t_valid && haz && m_cnt < 65535)
                m_cnt++;
            if (t_flush)
                m_valid = 1'b0;
            else if (t_valid && exp_rdy) begin
                m_valid = 1'b1;
                m_rec   = in_rec;
            end else if (m_valid && t_ready)
                m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          cnt0;
        logic [31:0] held_pc;
        n_tests  = 0;
        n_fail   = 0;
        m_valid  = 1'b0;
        m_cnt    = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        id_ready = 1'b0;

        // Reset held for two cycles; every output must read zero.
        repeat (2) @(posedge clk);
        #1;
        check("rst_id_valid",   32'(id_valid),    32'd0);
        check("rst_hazard_cnt", 32'(hazard_cnt),  32'd0);
        check("rst_id_pc",      id_pc,            32'd0);
        check("rst_id_imm",     id_imm,           32'd0);
        check("rst_id_opClass", 32'(id_opClass),  32'd0);
        check("rst_id_regWrite",32'(id_regWrite), 32'd0);
        check("rst_id_illegal", 32'(id_illegal),  32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("rst_if_ready",   32'(if_ready),    32'd1);

        // ALU_R streaming, one per cycle.
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 1'b1, 32'h0022_1800, 32'h100 + 32'(4 * i), 1'b1);
        check("alur_valid",  32'(id_valid),    32'd1);
        check("alur_op",     32'(id_opClass),  32'd0);
        check("alur_reg_1",  32'(id_reg_1),    32'd1);
        check("alur_reg_2",  32'(id_reg_2),    32'd2);
        check("alur_rw",     32'(id_regWrite), 32'd1);
        check("alur_pc",     id_pc,            32'h114);

        // Load-use: exactly one bubble and one stall count.
        cnt0 = int'(hazard_cnt);
        step(1'b0, 1'b0, 1'b1, 32'h4025_0004, 32'h200, 1'b1);
        check("lu_load_held", 32'(id_opClass), 32'd2);
        step(1'b0, 1'b0, 1'b1, 32'h00A3_0000, 32'h204, 1'b1);
        check("lu_bubble",    32'(id_valid),   32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h00A3_0000, 32'h204, 1'b1);
        check("lu_use_valid", 32'(id_valid),   32'd1);
        check("lu_use_rs",    32'(id_reg_1),   32'd5);
        check("lu_cnt",       32'(int'(hazard_cnt) - cnt0), 32'd1);

        // Backpressure: held outputs stay put, nothing is lost.
        held_pc = id_pc;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h2464_8000, 32'h300, 1'b0);
            check("bp_pc_stable", id_pc, held_pc);
        end
        step(1'b0, 1'b0, 1'b1, 32'h2464_8000, 32'h300, 1'b1);
        check("bp_new_pc", id_pc, 32'h300);
        check("aluI_zext", id_imm, 32'h0000_8000);

        // Flush with a held instruction and a fetch pending.
        step(1'b0, 1'b1, 1'b1, 32'h0022_1800, 32'h400, 1'b0);
        check("flush_valid", 32'(id_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("flush_no_accept", 32'(id_valid), 32'd0);

        // Immediate extension and illegal class.
        step(1'b0, 1'b0, 1'b1, 32'h4025_FFFC, 32'h500, 1'b1);
        check("load_sext", id_imm, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b1, 32'hC000_0000, 32'h504, 1'b1);
        check("illegal_flag", 32'(id_illegal),  32'd1);
        check("illegal_rw",   32'(id_regWrite), 32'd0);

        // Randomised traffic; narrow register range to provoke hazards often.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] instr;
            instr = {3'($urandom_range(0, 7)), 3'($urandom), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 16'($urandom)};
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), instr, 32'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
